// File: rtl/vita49_pkg.sv
// Shared VITA-49 IF-data header constants, FSM state type and small helpers.
package vita49_pkg;

   localparam logic [3:0] PKT_TYPE_IF_SID = 4'b0001;
   localparam logic [1:0] TSI_NONE        = 2'b00;
   localparam logic [1:0] TSF_NONE        = 2'b00;
   localparam logic [1:0] TSF_SAMPLE_CNT  = 2'b01;
   localparam logic [1:0] TSF_REAL_PS     = 2'b10;
   localparam logic [1:0] TSF_FREE_RUN    = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StTs,
      StPayload,
      StPad
   } state_e;

   // Upper 32 bits of the header word: type, C, T, reserved, TSI, TSF, count, size.
   function automatic logic [31:0] hdr_pack(input logic [1:0]  tsf,
                                            input logic [3:0]  cnt,
                                            input logic [15:0] size);
      return {PKT_TYPE_IF_SID, 1'b0, 1'b0, 2'b00, TSI_NONE, tsf, cnt, size};
   endfunction

   // Error counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/vita49_hdr_gen.sv
// Header word builder: per-channel 4-bit packet counts, stream ID and packet size.
module vita49_hdr_gen
   import vita49_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned LEN_W    = 12,
   parameter logic [1:0]  TSF_TYPE = 2'b01,
   localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [CH_W-1:0]   ch_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              ts_en_i,
   input  logic [31:0]       sid_base_i,
   input  logic              inc_i,
   output logic [63:0]       hdr_o
);

   logic [3:0]  cnt_q [NUM_CH];
   logic [3:0]  cnt_d [NUM_CH];
   logic [15:0] size;
   logic [31:0] sid;

   // Bump the count of the channel whose packet is closing (wraps mod 16).
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i) begin
         cnt_d[ch_i] = cnt_q[ch_i] + 4'd1;
      end
   end

   // Packet count registers, cleared on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            cnt_q[i] <= 4'd0;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Size in 32-bit words: header pair, optional timestamp pair, two per payload beat.
   always_comb begin
      size = 16'd2 + (ts_en_i ? 16'd2 : 16'd0) + (16'(len_i) << 1);
      sid  = sid_base_i + 32'(ch_i);
      hdr_o = {hdr_pack(ts_en_i ? TSF_TYPE : TSF_NONE, cnt_q[ch_i], size), sid};
   end

endmodule

// File: rtl/vita49_assem_mc.sv
// Multi-channel VITA-49 IF-data packet assembler with a single output register stage.
module vita49_assem_mc
   import vita49_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned LEN_W    = 12,
   parameter logic [1:0]  TSF_TYPE = 2'b01,
   localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic             AXIS_ACLK,
   input  logic             AXIS_ARESETN,
   input  logic             cfg_enable,
   input  logic             cfg_ts_en,
   input  logic [LEN_W-1:0] cfg_payload_words,
   input  logic [31:0]      cfg_sid_base,
   input  logic [63:0]      ts_in,
   input  logic [63:0]      S_AXIS_TDATA,
   input  logic [CH_W-1:0]  S_AXIS_TUSER,
   input  logic             S_AXIS_TVALID,
   input  logic             S_AXIS_TLAST,
   output logic             S_AXIS_TREADY,
   output logic [63:0]      M_AXIS_TDATA,
   output logic             M_AXIS_TVALID,
   output logic             M_AXIS_TLAST,
   output logic [7:0]       M_AXIS_TSTRB,
   input  logic             M_AXIS_TREADY,
   output logic [31:0]      err_len_cnt,
   output logic [31:0]      err_ch_cnt,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ts_en_q, ts_en_d;
   logic [63:0]      ts_q, ts_d;
   logic [31:0]      sid_base_q, sid_base_d;
   logic [LEN_W-1:0] beat_q, beat_d;
   logic [63:0]      m_tdata_q, m_tdata_d;
   logic             m_tvalid_q, m_tvalid_d;
   logic             m_tlast_q, m_tlast_d;
   logic [31:0]      err_len_q, err_len_d;
   logic [31:0]      err_ch_q, err_ch_d;

   logic             advance;
   logic             s_tready;
   logic             pkt_inc;
   logic [CH_W-1:0]  s_ch;
   logic [LEN_W-1:0] beat_nxt;
   logic [63:0]      hdr_word;

   // Output register may load when empty or when its word is being taken.
   assign advance  = !m_tvalid_q || M_AXIS_TREADY;
   // Out-of-range channel tags fold onto channel 0.
   assign s_ch     = (32'(S_AXIS_TUSER) < NUM_CH) ? S_AXIS_TUSER : '0;
   assign beat_nxt = beat_q + 1'b1;

   vita49_hdr_gen #(
      .NUM_CH   (NUM_CH),
      .LEN_W    (LEN_W),
      .TSF_TYPE (TSF_TYPE)
   ) u_hdr_gen (
      .clk_i      (AXIS_ACLK),
      .rst_ni     (AXIS_ARESETN),
      .ch_i       (ch_q),
      .len_i      (len_q),
      .ts_en_i    (ts_en_q),
      .sid_base_i (sid_base_q),
      .inc_i      (pkt_inc),
      .hdr_o      (hdr_word)
   );

   // Next-state, output-register load and error accounting.
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      len_d      = len_q;
      ts_en_d    = ts_en_q;
      ts_d       = ts_q;
      sid_base_d = sid_base_q;
      beat_d     = beat_q;
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;
      err_len_d  = err_len_q;
      err_ch_d   = err_ch_q;
      s_tready   = 1'b0;
      pkt_inc    = 1'b0;

      // Word taken and nothing new loaded below: register empties.
      if (advance) begin
         m_tdata_d  = '0;
         m_tvalid_d = 1'b0;
         m_tlast_d  = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            // Beat is only looked at here; it is consumed in StPayload.
            if (cfg_enable && (cfg_payload_words != '0) && S_AXIS_TVALID) begin
               ch_d       = s_ch;
               len_d      = cfg_payload_words;
               ts_en_d    = cfg_ts_en;
               ts_d       = ts_in;
               sid_base_d = cfg_sid_base;
               state_d    = StHdr;
            end
         end
         StHdr: begin
            if (advance) begin
               m_tdata_d  = hdr_word;
               m_tvalid_d = 1'b1;
               beat_d     = '0;
               state_d    = ts_en_q ? StTs : StPayload;
            end
         end
         StTs: begin
            if (advance) begin
               m_tdata_d  = ts_q;
               m_tvalid_d = 1'b1;
               state_d    = StPayload;
            end
         end
         StPayload: begin
            s_tready = advance;
            if (advance && S_AXIS_TVALID) begin
               beat_d     = beat_nxt;
               m_tdata_d  = S_AXIS_TDATA;
               m_tvalid_d = 1'b1;
               if (s_ch != ch_q) begin
                  err_ch_d = sat_inc(err_ch_q);
               end
               if (beat_nxt == len_q) begin
                  m_tlast_d = 1'b1;
                  pkt_inc   = 1'b1;
                  state_d   = StIdle;
                  if (!S_AXIS_TLAST) begin
                     err_len_d = sat_inc(err_len_q);
                  end
               end else if (S_AXIS_TLAST) begin
                  err_len_d = sat_inc(err_len_q);
                  state_d   = StPad;
               end
            end
         end
         StPad: begin
            if (advance) begin
               beat_d     = beat_nxt;
               m_tdata_d  = '0;
               m_tvalid_d = 1'b1;
               if (beat_nxt == len_q) begin
                  m_tlast_d = 1'b1;
                  pkt_inc   = 1'b1;
                  state_d   = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, packet context, output register and error counters.
   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q    <= StIdle;
         ch_q       <= '0;
         len_q      <= '0;
         ts_en_q    <= 1'b0;
         ts_q       <= '0;
         sid_base_q <= '0;
         beat_q     <= '0;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         err_len_q  <= '0;
         err_ch_q   <= '0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         len_q      <= len_d;
         ts_en_q    <= ts_en_d;
         ts_q       <= ts_d;
         sid_base_q <= sid_base_d;
         beat_q     <= beat_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         err_len_q  <= err_len_d;
         err_ch_q   <= err_ch_d;
      end
   end

   assign S_AXIS_TREADY = s_tready;
   assign M_AXIS_TDATA  = m_tdata_q;
   assign M_AXIS_TVALID = m_tvalid_q;
   assign M_AXIS_TLAST  = m_tlast_q;
   assign M_AXIS_TSTRB  = {8{m_tvalid_q}};
   assign err_len_cnt   = err_len_q;
   assign err_ch_cnt    = err_ch_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_vita49_assem_mc.sv
// Self-checking bench for vita49_assem_mc: packet table, scoreboard, corner-case sequences.
module tb_vita49_assem_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_enable, cfg_ts_en;
   logic [11:0] cfg_payload_words;
   logic [31:0] cfg_sid_base;
   logic [63:0] ts_in;
   logic [63:0] S_AXIS_TDATA;
   logic [1:0]  S_AXIS_TUSER;
   logic        S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
   logic [63:0] M_AXIS_TDATA;
   logic        M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
   logic [7:0]  M_AXIS_TSTRB;
   logic [31:0] err_len_cnt, err_ch_cnt;
   logic        busy;

   typedef struct {
      logic [63:0] d;
      logic        l;
   } exp_t;

   typedef struct {
      logic [1:0]  ch;
      logic [11:0] len;
      logic        ts_en;
      logic [63:0] ts;
      int          nbeats;
      logic [31:0] hdr_hi;
   } vec_t;

   exp_t       q[$];
   vec_t       tbl[4];
   logic [3:0] cnt_model[4];
   int         total = 0;
   int         bad = 0;
   int         seq = 0;
   bit         rand_rdy = 0;

   always #5 clk = ~clk;

   vita49_assem_mc dut (
      .AXIS_ACLK         (clk),
      .AXIS_ARESETN      (rst_n),
      .cfg_enable        (cfg_enable),
      .cfg_ts_en         (cfg_ts_en),
      .cfg_payload_words (cfg_payload_words),
      .cfg_sid_base      (cfg_sid_base),
      .ts_in             (ts_in),
      .S_AXIS_TDATA      (S_AXIS_TDATA),
      .S_AXIS_TUSER      (S_AXIS_TUSER),
      .S_AXIS_TVALID     (S_AXIS_TVALID),
      .S_AXIS_TLAST      (S_AXIS_TLAST),
      .S_AXIS_TREADY     (S_AXIS_TREADY),
      .M_AXIS_TDATA      (M_AXIS_TDATA),
      .M_AXIS_TVALID     (M_AXIS_TVALID),
      .M_AXIS_TLAST      (M_AXIS_TLAST),
      .M_AXIS_TSTRB      (M_AXIS_TSTRB),
      .M_AXIS_TREADY     (M_AXIS_TREADY),
      .err_len_cnt       (err_len_cnt),
      .err_ch_cnt        (err_ch_cnt),
      .busy              (busy)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endfunction

   // Expected upper header half, built field by field from the word layout.
   function automatic logic [31:0] mk_hdr(input logic ts_en, input logic [3:0] cnt,
                                          input logic [11:0] len);
      logic [31:0] size;
      size = 32'd2 + (ts_en ? 32'd2 : 32'd0) + 32'(len) * 32'd2;
      return 32'h1000_0000 | (ts_en ? 32'h0010_0000 : 32'h0) | (32'(cnt) << 16) | size;
   endfunction

   function automatic logic [63:0] dat(input int s, input int b);
      return {32'(s), 32'hB000_0000 | 32'(b)};
   endfunction

   // Present one source beat at a negedge; return at the negedge after it is taken.
   task automatic put_beat(input logic [63:0] d, input logic [1:0] u, input logic l);
      bit hs;
      hs = 0;
      S_AXIS_TDATA  = d;
      S_AXIS_TUSER  = u;
      S_AXIS_TLAST  = l;
      S_AXIS_TVALID = 1'b1;
      for (int n = 0; n < 300; n++) begin
         #1;
         if (S_AXIS_TREADY) begin
            hs = 1;
            break;
         end
         @(negedge clk);
      end
      if (!hs) begin
         total++;
         bad++;
         $display("FAIL put_beat_timeout: got ready=0 want ready=1");
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Queue the full expected packet, then drive its source burst.
   task automatic send_pkt(input logic [1:0] ch, input logic [11:0] len, input logic ts_en,
                           input logic [63:0] ts, input int nbeats, input int chg,
                           input logic [31:0] hdr_hi);
      logic [31:0] hh;
      seq++;
      cfg_ts_en         = ts_en;
      cfg_payload_words = len;
      ts_in             = ts;
      hh = (hdr_hi != 32'h0) ? hdr_hi : mk_hdr(ts_en, cnt_model[ch], len);
      q.push_back('{d: {hh, 32'h100 + 32'(ch)}, l: 1'b0});
      if (ts_en) q.push_back('{d: ts, l: 1'b0});
      for (int b = 0; b < int'(len); b++) begin
         q.push_back('{d: (b < nbeats) ? dat(seq, b) : 64'h0, l: (b == int'(len) - 1)});
      end
      cnt_model[ch] = cnt_model[ch] + 4'd1;
      for (int b = 0; b < nbeats; b++) begin
         put_beat(dat(seq, b), (b == chg) ? ch + 2'd1 : ch, b == nbeats - 1);
      end
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 500 && q.size() != 0; n++) begin
         @(negedge clk);
         #3;
      end
      chk("drain_left", 64'(q.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   // Random backpressure, changed only at negedges.
   initial begin
      forever begin
         @(negedge clk);
         if (rand_rdy) M_AXIS_TREADY = 1'($urandom_range(0, 1));
      end
   end

   // Scoreboard monitor: pops on each handshake, checks words held while stalled.
   initial begin : mon
      logic        stall;
      logic [63:0] held;
      exp_t        e;
      stall = 0;
      held  = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            stall = 0;
         end else begin
            if (stall) begin
               chk("hold_valid", 64'(M_AXIS_TVALID), 64'd1);
               chk("hold_data", M_AXIS_TDATA, held);
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_word: got %h want none", M_AXIS_TDATA);
               end else begin
                  e = q.pop_front();
                  chk("word", M_AXIS_TDATA, e.d);
                  chk("tlast", 64'(M_AXIS_TLAST), 64'(e.l));
                  chk("tstrb", 64'(M_AXIS_TSTRB), 64'hFF);
               end
            end
            stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            held  = M_AXIS_TDATA;
         end
      end
   end

   initial begin
      tbl[0] = '{ch: 2'd2, len: 12'd4, ts_en: 1'b0, ts: 64'h0, nbeats: 4, hdr_hi: 32'h1000_000A};
      tbl[1] = '{ch: 2'd0, len: 12'd2, ts_en: 1'b1, ts: 64'h0000_0001_0000_0020, nbeats: 2,
                 hdr_hi: 32'h1010_0008};
      tbl[2] = '{ch: 2'd2, len: 12'd1, ts_en: 1'b0, ts: 64'h0, nbeats: 1, hdr_hi: 32'h1001_0004};
      tbl[3] = '{ch: 2'd0, len: 12'd3, ts_en: 1'b1, ts: 64'hDEAD_BEEF_0123_4567, nbeats: 3,
                 hdr_hi: 32'h1011_000A};
      for (int i = 0; i < 4; i++) cnt_model[i] = 4'd0;
      cfg_enable        = 1'b1;
      cfg_ts_en         = 1'b0;
      cfg_payload_words = 12'd4;
      cfg_sid_base      = 32'h100;
      ts_in             = '0;
      S_AXIS_TDATA      = '0;
      S_AXIS_TUSER      = '0;
      S_AXIS_TVALID     = 1'b0;
      S_AXIS_TLAST      = 1'b0;
      M_AXIS_TREADY     = 1'b1;

      #12;
      chk("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
      chk("rst_tlast", 64'(M_AXIS_TLAST), 64'd0);
      chk("rst_tdata", M_AXIS_TDATA, 64'd0);
      chk("rst_tready", 64'(S_AXIS_TREADY), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err_len", 64'(err_len_cnt), 64'd0);
      chk("rst_err_ch", 64'(err_ch_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         send_pkt(tbl[i].ch, tbl[i].len, tbl[i].ts_en, tbl[i].ts, tbl[i].nbeats, -1,
                  tbl[i].hdr_hi);
      end

      // 17 back-to-back packets on ch1 (count wraps), ch3 interleaved with its own count.
      for (int i = 0; i < 17; i++) begin
         send_pkt(2'd1, 12'd1, 1'b0, 64'h0, 1, -1, 32'h0);
         if (i % 5 == 2) send_pkt(2'd3, 12'd2, 1'b0, 64'h0, 2, -1, 32'h0);
      end

      // Short burst: two beats into a four-beat packet, padded with zeros.
      send_pkt(2'd2, 12'd4, 1'b0, 64'h0, 2, -1, 32'h0);
      drain();
      chk("err_len_short", 64'(err_len_cnt), 64'd1);

      // Long burst: three beats with len=2; the third opens its own packet (len=1).
      seq++;
      cfg_ts_en         = 1'b0;
      cfg_payload_words = 12'd2;
      q.push_back('{d: {mk_hdr(1'b0, cnt_model[0], 12'd2), 32'h100}, l: 1'b0});
      q.push_back('{d: dat(seq, 0), l: 1'b0});
      q.push_back('{d: dat(seq, 1), l: 1'b1});
      cnt_model[0] = cnt_model[0] + 4'd1;
      put_beat(dat(seq, 0), 2'd0, 1'b0);
      put_beat(dat(seq, 1), 2'd0, 1'b0);
      chk("err_len_long", 64'(err_len_cnt), 64'd2);
      cfg_payload_words = 12'd1;
      q.push_back('{d: {mk_hdr(1'b0, cnt_model[0], 12'd1), 32'h100}, l: 1'b0});
      q.push_back('{d: dat(seq, 2), l: 1'b1});
      cnt_model[0] = cnt_model[0] + 4'd1;
      put_beat(dat(seq, 2), 2'd0, 1'b1);
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      drain();
      chk("err_len_after", 64'(err_len_cnt), 64'd2);

      // Random backpressure with a channel change on the third beat.
      rand_rdy = 1;
      send_pkt(2'd3, 12'd5, 1'b1, 64'h0000_0042_0000_0777, 5, 2, 32'h0);
      send_pkt(2'd1, 12'd3, 1'b0, 64'h0, 3, -1, 32'h0);
      drain();
      rand_rdy      = 0;
      M_AXIS_TREADY = 1'b1;
      chk("err_ch", 64'(err_ch_cnt), 64'd1);

      // cfg_enable dropped mid-packet: packet completes, nothing new starts.
      seq++;
      cfg_payload_words = 12'd3;
      q.push_back('{d: {mk_hdr(1'b0, cnt_model[2], 12'd3), 32'h102}, l: 1'b0});
      for (int b = 0; b < 3; b++) q.push_back('{d: dat(seq, b), l: (b == 2)});
      cnt_model[2] = cnt_model[2] + 4'd1;
      put_beat(dat(seq, 0), 2'd2, 1'b0);
      cfg_enable = 1'b0;
      put_beat(dat(seq, 1), 2'd2, 1'b0);
      put_beat(dat(seq, 2), 2'd2, 1'b1);
      S_AXIS_TDATA = 64'h5555_5555_5555_5555;
      S_AXIS_TLAST = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      chk("dis_busy", 64'(busy), 64'd0);
      chk("dis_tready", 64'(S_AXIS_TREADY), 64'd0);
      S_AXIS_TVALID = 1'b0;
      drain();
      cfg_enable = 1'b1;

      // Reset in the middle of a payload.
      seq++;
      cfg_payload_words = 12'd4;
      q.push_back('{d: {mk_hdr(1'b0, cnt_model[2], 12'd4), 32'h102}, l: 1'b0});
      q.push_back('{d: dat(seq, 0), l: 1'b0});
      q.push_back('{d: dat(seq, 1), l: 1'b0});
      put_beat(dat(seq, 0), 2'd2, 1'b0);
      put_beat(dat(seq, 1), 2'd2, 1'b0);
      #3;
      S_AXIS_TVALID = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
      chk("mid_rst_tdata", M_AXIS_TDATA, 64'd0);
      chk("mid_rst_tlast", 64'(M_AXIS_TLAST), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_err_len", 64'(err_len_cnt), 64'd0);
      chk("mid_rst_err_ch", 64'(err_ch_cnt), 64'd0);
      chk("mid_rst_pending", 64'(q.size()), 64'd0);
      for (int i = 0; i < 4; i++) cnt_model[i] = 4'd0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_pkt(2'd2, 12'd4, 1'b0, 64'h0, 4, -1, 32'h1000_000A);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
